// File: rtl/frontend_pkg.sv
// Shared types and constants for the IF/ID front-end sequencing controller.
package frontend_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SYS_DRAIN = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_t;

  localparam int          DEF_FLUSH_CYCLES = 2;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam logic [31:0] SYS_RET_OFFSET   = 32'd4;

  // Return address after a syscall; wraps modulo 2^32.
  function automatic logic [31:0] sys_return_pc(input logic [31:0] pc);
    return pc + SYS_RET_OFFSET;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
  localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count register: clear wins over increment, increment stops at MAX_VAL.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_clear) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE_VAL;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/frontend_ctrl.sv
// Front-end sequencing controller: IF/ID stalls, decode-queue flush and
// a single redirect per flush for mispredict, syscall and exception.
module frontend_ctrl
  import frontend_pkg::*;
#(
  parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DQ_FULL,
  input  logic             DQ_EMPTY,
  input  logic             ID_STALL_REQ,
  input  logic             MISPRED,
  input  logic [31:0]      MISPRED_PC,
  input  logic             SYS,
  input  logic [31:0]      SYS_PC,
  input  logic             SYS_DONE,
  input  logic             EXC,
  output logic             STALL_IF,
  output logic             STALL_ID,
  output logic             FLUSH_DQ,
  output logic             REDIRECT_VALID,
  output logic [31:0]      REDIRECT_PC,
  output logic             BUSY,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [3:0] TIMER_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_timer;
  logic [3:0]  w_timer_nxt;
  logic [31:0] r_target;
  logic [31:0] w_target_nxt;
  logic [31:0] r_redirect_pc;
  logic        w_evt;
  logic [31:0] w_evt_tgt;
  logic        w_cnt_inc;
  logic        w_stall_if;
  logic        w_stall_id;
  logic        w_flush_dq;
  logic        w_redirect_valid;
  logic        w_load_redirect;

  // Exception outranks mispredict when both arrive together.
  assign w_evt     = EXC | MISPRED;
  assign w_evt_tgt = EXC ? EXC_VECTOR : MISPRED_PC;

  // Next-state, target capture and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_target_nxt     = r_target;
    w_stall_if       = 1'b1;
    w_stall_id       = 1'b1;
    w_flush_dq       = 1'b0;
    w_redirect_valid = 1'b0;
    w_cnt_inc        = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall_if = DQ_FULL;
        w_stall_id = DQ_EMPTY | ID_STALL_REQ;
        if (w_evt) begin
          w_state_nxt  = ST_FLUSH;
          w_target_nxt = w_evt_tgt;
        end else if (SYS) begin
          w_state_nxt  = ST_SYS_DRAIN;
          w_target_nxt = sys_return_pc(SYS_PC);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SYS_DRAIN: begin
        if (w_evt) begin
          w_state_nxt  = ST_FLUSH;
          w_target_nxt = w_evt_tgt;
        end else if (SYS_DONE) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_SYS_DRAIN;
        end
      end
      ST_FLUSH: begin
        w_flush_dq = 1'b1;
        if (w_evt) begin
          w_state_nxt  = ST_FLUSH;
          w_target_nxt = w_evt_tgt;
        end else if (r_timer == 4'd0) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      ST_REDIRECT: begin
        w_stall_if       = 1'b0;
        w_redirect_valid = 1'b1;
        if (w_evt) begin
          w_state_nxt  = ST_FLUSH;
          w_target_nxt = w_evt_tgt;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    // Any entry into FLUSH, including a restart from within FLUSH, reloads the timer.
    if ((w_state_nxt == ST_FLUSH) && ((r_state != ST_FLUSH) || w_evt)) begin
      w_cnt_inc   = 1'b1;
      w_timer_nxt = TIMER_LOAD;
    end else begin
      w_cnt_inc = 1'b0;
    end
  end

  assign w_load_redirect = (r_state == ST_FLUSH) && (w_state_nxt == ST_REDIRECT);

  // Sequencing state and captured redirect target.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_RUN;
      r_timer  <= 4'd0;
      r_target <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_target <= w_target_nxt;
    end
  end

  // REDIRECT_PC is presented for the redirect cycle and then held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_redirect_pc <= 32'd0;
    end else if (w_load_redirect) begin
      r_redirect_pc <= r_target;
    end else begin
      r_redirect_pc <= r_redirect_pc;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_inc   (w_cnt_inc),
    .i_clear (1'b0),
    .o_count (FLUSH_CNT)
  );

  assign STALL_IF       = RESET | w_stall_if;
  assign STALL_ID       = RESET | w_stall_id;
  assign FLUSH_DQ       = w_flush_dq;
  assign REDIRECT_VALID = w_redirect_valid;
  assign REDIRECT_PC    = r_redirect_pc;
  assign BUSY           = (r_state != ST_RUN);

endmodule

// File: tb/tb_frontend_ctrl.sv
// Self-checking bench: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=1/CNT_W=2) checked every cycle against an event-level model.
module tb_frontend_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DQ_FULL = 1'b0, DQ_EMPTY = 1'b0, ID_STALL_REQ = 1'b0;
  logic        MISPRED = 1'b0, SYS = 1'b0, SYS_DONE = 1'b0, EXC = 1'b0;
  logic [31:0] MISPRED_PC = 32'd0, SYS_PC = 32'd0;

  logic        stall_if [2];
  logic        stall_id [2];
  logic        flush_dq [2];
  logic        rv       [2];
  logic        busy     [2];
  logic [31:0] rpc      [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: remaining flush cycles, redirect/drain flags, targets, count.
  int          m_left  [2];
  bit          m_redir [2];
  bit          m_drain [2];
  logic [31:0] m_tgt   [2];
  logic [31:0] m_rpc   [2];
  int          m_cnt   [2];

  always #5 CLK = ~CLK;

  frontend_ctrl #(.FLUSH_CYCLES(2), .EXC_VECTOR(VEC), .CNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .DQ_FULL(DQ_FULL), .DQ_EMPTY(DQ_EMPTY),
    .ID_STALL_REQ(ID_STALL_REQ), .MISPRED(MISPRED), .MISPRED_PC(MISPRED_PC),
    .SYS(SYS), .SYS_PC(SYS_PC), .SYS_DONE(SYS_DONE), .EXC(EXC),
    .STALL_IF(stall_if[0]), .STALL_ID(stall_id[0]), .FLUSH_DQ(flush_dq[0]),
    .REDIRECT_VALID(rv[0]), .REDIRECT_PC(rpc[0]), .BUSY(busy[0]), .FLUSH_CNT(cnt0));

  frontend_ctrl #(.FLUSH_CYCLES(1), .EXC_VECTOR(VEC), .CNT_W(2)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .DQ_FULL(DQ_FULL), .DQ_EMPTY(DQ_EMPTY),
    .ID_STALL_REQ(ID_STALL_REQ), .MISPRED(MISPRED), .MISPRED_PC(MISPRED_PC),
    .SYS(SYS), .SYS_PC(SYS_PC), .SYS_DONE(SYS_DONE), .EXC(EXC),
    .STALL_IF(stall_if[1]), .STALL_ID(stall_id[1]), .FLUSH_DQ(flush_dq[1]),
    .REDIRECT_VALID(rv[1]), .REDIRECT_PC(rpc[1]), .BUSY(busy[1]), .FLUSH_CNT(cnt1));

  function automatic int fc(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int maxc(int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(1);
  endtask

  // Event-level model of the sequencing rules.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        m_left[i]  <= 0;
        m_redir[i] <= 1'b0;
        m_drain[i] <= 1'b0;
        m_tgt[i]   <= 32'd0;
        m_rpc[i]   <= 32'd0;
        m_cnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (EXC || MISPRED) begin
          m_tgt[i]   <= EXC ? VEC : MISPRED_PC;
          m_left[i]  <= fc(i);
          m_redir[i] <= 1'b0;
          m_drain[i] <= 1'b0;
          m_cnt[i]   <= (m_cnt[i] >= maxc(i)) ? m_cnt[i] : m_cnt[i] + 1;
        end else if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_redir[i] <= 1'b1;
            m_rpc[i]   <= m_tgt[i];
          end
        end else if (m_redir[i]) begin
          m_redir[i] <= 1'b0;
        end else if (m_drain[i]) begin
          if (SYS_DONE) begin
            m_drain[i] <= 1'b0;
            m_left[i]  <= fc(i);
            m_cnt[i]   <= (m_cnt[i] >= maxc(i)) ? m_cnt[i] : m_cnt[i] + 1;
          end
        end else if (SYS) begin
          m_drain[i] <= 1'b1;
          m_tgt[i]   <= SYS_PC + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit run;
        run = (m_left[i] == 0) && !m_redir[i] && !m_drain[i];
        chk($sformatf("i%0d.STALL_IF", i), {31'd0, stall_if[i]},
            {31'd0, RESET ? 1'b1 : (run ? DQ_FULL : !m_redir[i])});
        chk($sformatf("i%0d.STALL_ID", i), {31'd0, stall_id[i]},
            {31'd0, RESET ? 1'b1 : (run ? (DQ_EMPTY | ID_STALL_REQ) : 1'b1)});
        chk($sformatf("i%0d.FLUSH_DQ", i), {31'd0, flush_dq[i]}, {31'd0, m_left[i] > 0});
        chk($sformatf("i%0d.REDIRECT_VALID", i), {31'd0, rv[i]}, {31'd0, m_redir[i]});
        chk($sformatf("i%0d.BUSY", i), {31'd0, busy[i]}, {31'd0, !run});
        chk($sformatf("i%0d.REDIRECT_PC", i), rpc[i], m_rpc[i]);
      end
      chk("i0.FLUSH_CNT", {16'd0, cnt0}, m_cnt[0]);
      chk("i1.FLUSH_CNT", {30'd0, cnt1}, m_cnt[1]);
    end
  end

  initial begin
    #2;
    RESET = 1'b1;
    #1;
    chk_en = 1'b1;
    step(1);
    // Reset state
    chk("rst.STALL_IF", {31'd0, stall_if[0]}, 32'd1);
    chk("rst.STALL_ID", {31'd0, stall_id[0]}, 32'd1);
    chk("rst.BUSY", {31'd0, busy[0]}, 32'd0);
    chk("rst.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd0);
    chk("rst.REDIRECT_PC", rpc[0], 32'd0);
    RESET = 1'b0;
    step(1);

    // RUN stall decode
    DQ_FULL = 1'b1; DQ_EMPTY = 1'b0;
    #1;
    chk("run.STALL_IF", {31'd0, stall_if[0]}, 32'd1);
    chk("run.STALL_ID", {31'd0, stall_id[0]}, 32'd0);
    chk("run.BUSY", {31'd0, busy[0]}, 32'd0);
    chk("run.FLUSH_CNT", {16'd0, cnt0}, 32'd0);
    DQ_EMPTY = 1'b1;
    #1;
    chk("run.STALL_ID_empty", {31'd0, stall_id[0]}, 32'd1);
    DQ_FULL = 1'b0; DQ_EMPTY = 1'b0;
    step(1);

    // Mispredict timeline
    MISPRED = 1'b1; MISPRED_PC = 32'h0040_0100;
    step(1);
    MISPRED = 1'b0;
    chk("mp.n1.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd1);
    chk("mp.n1.FLUSH_DQ_fc1", {31'd0, flush_dq[1]}, 32'd1);
    step(1);
    chk("mp.n2.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd1);
    chk("mp.n2.RV_fc1", {31'd0, rv[1]}, 32'd1);
    chk("mp.n2.RPC_fc1", rpc[1], 32'h0040_0100);
    step(1);
    chk("mp.n3.RV", {31'd0, rv[0]}, 32'd1);
    chk("mp.n3.RPC", rpc[0], 32'h0040_0100);
    chk("mp.n3.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd0);
    step(1);
    chk("mp.n4.BUSY", {31'd0, busy[0]}, 32'd0);
    chk("mp.n4.FLUSH_CNT", {16'd0, cnt0}, 32'd1);

    // Syscall with PC wrap
    do_reset();
    SYS = 1'b1; SYS_PC = 32'hFFFF_FFFC;
    step(1);
    SYS = 1'b0;
    chk("sys.drain.STALL_IF", {31'd0, stall_if[0]}, 32'd1);
    chk("sys.drain.STALL_ID", {31'd0, stall_id[0]}, 32'd1);
    chk("sys.drain.BUSY", {31'd0, busy[0]}, 32'd1);
    step(4);
    SYS_DONE = 1'b1;
    step(1);
    SYS_DONE = 1'b0;
    chk("sys.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd1);
    step(1);
    chk("sys.RV_fc1", {31'd0, rv[1]}, 32'd1);
    step(1);
    chk("sys.RV", {31'd0, rv[0]}, 32'd1);
    chk("sys.RPC", rpc[0], 32'h0000_0000);

    // EXC + MISPRED (+SYS_DONE) in SYS_DRAIN
    do_reset();
    SYS = 1'b1; SYS_PC = 32'h0000_1000;
    step(1);
    SYS = 1'b0; EXC = 1'b1; MISPRED = 1'b1; MISPRED_PC = 32'h0000_1234; SYS_DONE = 1'b1;
    step(1);
    EXC = 1'b0; MISPRED = 1'b0; SYS_DONE = 1'b0;
    chk("exc.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd1);
    step(2);
    chk("exc.RV", {31'd0, rv[0]}, 32'd1);
    chk("exc.RPC", rpc[0], VEC);
    chk("exc.FLUSH_CNT", {16'd0, cnt0}, 32'd1);
    step(3);
    chk("exc.dropped.BUSY", {31'd0, busy[0]}, 32'd0);

    // Restart during FLUSH
    do_reset();
    MISPRED = 1'b1; MISPRED_PC = 32'h0000_0100;
    step(1);
    MISPRED_PC = 32'h0000_0200;
    step(1);
    MISPRED = 1'b0;
    chk("rs.n2.RV", {31'd0, rv[0]}, 32'd0);
    step(1);
    chk("rs.n3.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd1);
    step(1);
    chk("rs.n4.RV", {31'd0, rv[0]}, 32'd1);
    chk("rs.n4.RPC", rpc[0], 32'h0000_0200);
    chk("rs.FLUSH_CNT", {16'd0, cnt0}, 32'd2);

    // Reset in second FLUSH cycle
    do_reset();
    MISPRED = 1'b1; MISPRED_PC = 32'h0000_0300;
    step(1);
    MISPRED = 1'b0;
    step(1);
    RESET = 1'b1;
    #1;
    chk("mr.BUSY", {31'd0, busy[0]}, 32'd0);
    chk("mr.FLUSH_DQ", {31'd0, flush_dq[0]}, 32'd0);
    chk("mr.STALL_IF", {31'd0, stall_if[0]}, 32'd1);
    step(1);
    RESET = 1'b0;
    step(2);
    chk("mr.RV", {31'd0, rv[0]}, 32'd0);
    chk("mr.RPC", rpc[0], 32'd0);

    // Saturation of the 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      MISPRED = 1'b1; MISPRED_PC = 32'h0000_1000 + 32'(k * 16);
      step(1);
      MISPRED = 1'b0;
      step(4);
    end
    chk("sat.FLUSH_CNT_w2", {30'd0, cnt1}, 32'd3);
    chk("sat.FLUSH_CNT_w16", {16'd0, cnt0}, 32'd5);

    // Mixed traffic, model-checked each cycle
    for (int c = 0; c < 200; c++) begin
      DQ_FULL      = ($urandom_range(0, 3) == 0);
      DQ_EMPTY     = ($urandom_range(0, 3) == 0);
      ID_STALL_REQ = ($urandom_range(0, 3) == 0);
      MISPRED      = ($urandom_range(0, 11) == 0);
      EXC          = ($urandom_range(0, 23) == 0);
      SYS          = ($urandom_range(0, 7) == 0);
      SYS_DONE     = ($urandom_range(0, 5) == 0);
      MISPRED_PC   = $urandom;
      SYS_PC       = $urandom;
      step(1);
    end
    MISPRED = 1'b0; EXC = 1'b0; SYS = 1'b0; SYS_DONE = 1'b1;
    step(8);
    SYS_DONE = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frontend_ctrl.md
# frontend_ctrl

Front-end sequencing controller for the 8-entry decode queue between IF and ID. It generates the IF/ID stall signals and the decode-queue flush, and handles the three redirect sources: branch mispredict, syscall and exception. After each flush it issues exactly one redirect PC to IF. It also keeps a saturating count of flushes for performance debug.

## Interface
- FLUSH_CYCLES, 2: cycles FLUSH_DQ is held per flush; legal range 1..15.
- EXC_VECTOR, 32'h8000_0180: redirect target for exceptions.
- CNT_W, 16: width of FLUSH_CNT.
- CLK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DQ_FULL  in  1  decode queue full (all 8 valid bits set).
- DQ_EMPTY  in  1  decode queue empty.
- ID_STALL_REQ  in  1  back end cannot accept from ID.
- MISPRED  in  1  branch mispredict pulse; valid with MISPRED_PC.
- MISPRED_PC  in  32  correct target of the mispredicted branch.
- SYS  in  1  syscall decoded in ID; valid with SYS_PC.
- SYS_PC  in  32  PC of the syscall instruction.
- SYS_DONE  in  1  syscall handler finished.
- EXC  in  1  exception pulse.
- STALL_IF  out  1  stall fetch.
- STALL_ID  out  1  stall decode.
- FLUSH_DQ  out  1  clear all decode-queue entries and pointers.
- REDIRECT_VALID  out  1  one-cycle strobe: IF loads REDIRECT_PC.
- REDIRECT_PC  out  32  redirect target, registered.
- BUSY  out  1  state is not RUN.
- FLUSH_CNT  out  CNT_W  saturating count of FLUSH entries.

## Operation
- States: RUN, SYS_DRAIN, FLUSH, REDIRECT. The state register and a 4-bit flush timer are the only sequencing state.
- Event priority in any state is EXC > MISPRED > SYS.
- **RUN**
  - STALL_IF = DQ_FULL.
  - STALL_ID = DQ_EMPTY | ID_STALL_REQ.
  - FLUSH_DQ = 0, REDIRECT_VALID = 0.
- **RUN exits**
  - EXC: target ← EXC_VECTOR, go to FLUSH.
  - MISPRED: target ← MISPRED_PC, go to FLUSH.
  - SYS: target ← SYS_PC + 4 (mod 2^32), go to SYS_DRAIN.
- **SYS_DRAIN**
  - STALL_IF = 1, STALL_ID = 1.
  - On SYS_DONE, go to FLUSH and keep the captured target.
  - EXC or MISPRED here overrides: the syscall is dropped, the new target is captured, go to FLUSH.
- **FLUSH**
  - FLUSH_DQ = 1, STALL_IF = 1, STALL_ID = 1.
  - The timer loads FLUSH_CYCLES-1 on entry and decrements each cycle. At 0, go to REDIRECT.
  - EXC or MISPRED here recaptures the target and reloads the timer. This restarts the flush and FLUSH_CNT increments again.
- **REDIRECT**
  - REDIRECT_VALID = 1, STALL_IF = 0, STALL_ID = 1, FLUSH_DQ = 0.
  - Next state is RUN.
  - EXC or MISPRED here goes to FLUSH with the new target, and the redirect strobe still fires this cycle.
- SYS is ignored outside RUN; the syscall is refetched after the redirect.
- FLUSH_CNT increments on every cycle whose next state is FLUSH while either the current state is not FLUSH, or the current state is FLUSH and a restart occurs. It holds at 2^CNT_W-1.
- REDIRECT_PC holds its value between redirects.

## Timing
- Reset, asynchronous:
  - State = RUN, timer = 0, REDIRECT_PC = 0, FLUSH_CNT = 0.
  - FLUSH_DQ = 0, REDIRECT_VALID = 0, BUSY = 0.
  - While RESET is high, STALL_IF = STALL_ID = 1 (gated combinationally).
  - Reset in mid-operation abandons any flush or syscall with no redirect issued.
- Stall and flush outputs are decoded combinationally from the state, plus the DQ_FULL/DQ_EMPTY/ID_STALL_REQ inputs in RUN.
- REDIRECT_PC and the target are registered.
- Mispredict or exception sampled at edge N:
  - FLUSH_DQ high for cycles N+1 .. N+FLUSH_CYCLES.
  - REDIRECT_VALID in cycle N+FLUSH_CYCLES+1.
  - RUN from N+FLUSH_CYCLES+2.
- Syscall sampled at edge N: SYS_DRAIN from N+1. SYS_DONE sampled at edge M gives FLUSH from M+1, then the same sequence as a mispredict.
- If SYS_DONE and MISPRED are sampled on the same edge, MISPRED wins.
- With FLUSH_CYCLES = 1, FLUSH lasts exactly one cycle.

## Structure
- Package frontend_pkg holds:
  - the state enum (RUN, SYS_DRAIN, FLUSH, REDIRECT);
  - default FLUSH_CYCLES and EXC_VECTOR constants;
  - the syscall return offset, 4.
- Sub-module sat_counter (parameter W; inc, clear; saturating) implements FLUSH_CNT.
- Everything else is flat in frontend_ctrl.

## Test plan
- Reset, then RUN with DQ_FULL=1 and DQ_EMPTY=0 → STALL_IF=1, STALL_ID=0, BUSY=0, FLUSH_CNT=0. Then DQ_EMPTY=1 → STALL_ID=1.
- MISPRED at edge 10 with MISPRED_PC=32'h0040_0100, FLUSH_CYCLES=2 → FLUSH_DQ in cycles 11–12; REDIRECT_VALID in cycle 13 with REDIRECT_PC=32'h0040_0100; RUN at 14; FLUSH_CNT=1.
- SYS with SYS_PC=32'hFFFF_FFFC → SYS_DRAIN with both stalls high. SYS_DONE five cycles later → flush, then redirect to 32'h0000_0000 (wrap).
- In SYS_DRAIN, EXC and MISPRED on the same edge → flush, then redirect to 32'h8000_0180; the syscall is dropped; FLUSH_CNT=1.
- MISPRED to 32'h100 and, during FLUSH, MISPRED to 32'h200 → timer restarts; a single REDIRECT to 32'h200; FLUSH_CNT increments by 2.
- RESET asserted in the second FLUSH cycle → immediate RUN, no REDIRECT_VALID. With CNT_W=2, five flushes → FLUSH_CNT=3.
